// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the two-stage core: opcodes, branch funct3 codes,
// the canonical NOP and the writeback source select.
package riscv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM, WB_AUIPC} wb_sel_e;

endpackage

// File: rtl/branch_unit.sv
// Conditional branch comparator: purely combinational, no state, no backpressure.
module branch_unit
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) < $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 < rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_processor.sv
// Two-stage (IF | EX) RV32I core; EX completes in one cycle, taken redirects cost one bubble.
// stall freezes all state; halted (ECALL/EBREAK or misaligned target) freezes until rst.
module pipe_processor
  import riscv_pkg::*;
#(
  parameter logic [31:0]              RESET_PC    = 32'h0000_0000,
  parameter bit                       HALT_ON_SYS = 1'b1,
  parameter int                       IMEM_WORDS  = 64,
  parameter int                       DMEM_WORDS  = 64,
  parameter logic [IMEM_WORDS*32-1:0] IMEM_INIT   = {IMEM_WORDS{NOP_INST}}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic        retire_valid,
  output logic [31:0] retire_pc,
  output logic [31:0] retire_inst,
  output logic        halted,
  output logic        trap_misalign
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  logic [31:0] pc_f, ex_pc, ex_inst, fetch_inst;
  logic        ex_valid, advance, commit, mis, br_taken;
  logic [31:0] rf [32];
  logic [31:0] dmem [DMEM_WORDS];

  // Instruction ROM contents come from IMEM_INIT (word i at bits [32*i +: 32]).
  assign fetch_inst = IMEM_INIT[{pc_f[IW+1:2], 5'd0} +: 32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, rs1_val, rs2_val;

  assign opcode  = ex_inst[6:0];
  assign rd      = ex_inst[11:7];
  assign funct3  = ex_inst[14:12];
  assign rs1     = ex_inst[19:15];
  assign rs2     = ex_inst[24:20];
  assign imm_i   = {{20{ex_inst[31]}}, ex_inst[31:20]};
  assign imm_s   = {{20{ex_inst[31]}}, ex_inst[31:25], ex_inst[11:7]};
  assign imm_b   = {{19{ex_inst[31]}}, ex_inst[31], ex_inst[7], ex_inst[30:25], ex_inst[11:8], 1'b0};
  assign imm_j   = {{11{ex_inst[31]}}, ex_inst[31], ex_inst[19:12], ex_inst[20], ex_inst[30:21], 1'b0};
  assign imm_u   = {ex_inst[31:12], 12'd0};
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;

  always_comb begin
    alu_b = (opcode == OP) ? rs2_val : imm_i;
    shamt = alu_b[4:0];
    case (funct3)
      3'b000:  alu_res = (opcode == OP && ex_inst[30]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_res = rs1_val << shamt;
      3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_res = {31'd0, rs1_val < alu_b};
      3'b100:  alu_res = rs1_val ^ alu_b;
      3'b101:  alu_res = ex_inst[30] ? $signed(rs1_val) >>> shamt : rs1_val >> shamt;
      3'b110:  alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  branch_unit u_branch (
    .funct3 (funct3),
    .rs1    (rs1_val),
    .rs2    (rs2_val),
    .taken  (br_taken)
  );

  wb_sel_e     wb_sel;
  logic        rf_we, dm_we, redirect, sys_halt;
  logic [31:0] target;

  always_comb begin
    wb_sel   = WB_ALU;
    rf_we    = 1'b0;
    dm_we    = 1'b0;
    redirect = 1'b0;
    sys_halt = 1'b0;
    target   = 32'd0;
    case (opcode)
      OP, OP_IMM: rf_we = 1'b1;
      LOAD:   begin rf_we = 1'b1; wb_sel = WB_MEM; end
      STORE:  dm_we = 1'b1;
      BRANCH: begin redirect = br_taken; target = ex_pc + imm_b; end
      JAL:    begin rf_we = 1'b1; wb_sel = WB_PC4; redirect = 1'b1; target = ex_pc + imm_j; end
      JALR:   begin
        rf_we = 1'b1; wb_sel = WB_PC4; redirect = 1'b1;
        target = (rs1_val + imm_i) & 32'hFFFF_FFFE;
      end
      LUI:    begin rf_we = 1'b1; wb_sel = WB_IMM; end
      AUIPC:  begin rf_we = 1'b1; wb_sel = WB_AUIPC; end
      // CSR forms (funct3 != 0) fall through as NOPs.
      SYSTEM: sys_halt = HALT_ON_SYS && (funct3 == 3'b000);
      default: ;
    endcase
  end

  logic [31:0]   mem_addr, ld_word, ld_data, wb_data;
  logic [DW-1:0] didx;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign mem_addr = rs1_val + ((opcode == STORE) ? imm_s : imm_i);
  assign didx     = mem_addr[DW+1:2];
  assign ld_word  = dmem[didx];

  always_comb begin
    ld_byte = ld_word[{mem_addr[1:0], 3'b000} +: 8];
    ld_half = ld_word[{mem_addr[1], 4'b0000} +: 16];
    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
    case (wb_sel)
      WB_MEM:   wb_data = ld_data;
      WB_PC4:   wb_data = ex_pc + 32'd4;
      WB_IMM:   wb_data = imm_u;
      WB_AUIPC: wb_data = ex_pc + imm_u;
      default:  wb_data = alu_res;
    endcase
  end

  // A misaligned redirect blocks its own retirement and any architectural write.
  assign mis          = redirect && (target[1:0] != 2'b00);
  assign advance      = ~stall & ~halted;
  assign commit       = ex_valid & advance & ~mis & ~rst;
  assign retire_valid = commit;
  assign retire_pc    = ex_pc;
  assign retire_inst  = ex_inst;

  always_ff @(posedge clk) begin
    if (commit && rf_we && rd != 5'd0) rf[rd] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (commit && dm_we) begin
      case (funct3[1:0])
        2'b00:   dmem[didx][{mem_addr[1:0], 3'b000} +: 8] <= rs2_val[7:0];
        2'b01:   dmem[didx][{mem_addr[1], 4'b0000} +: 16] <= rs2_val[15:0];
        default: dmem[didx] <= rs2_val;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f          <= RESET_PC;
      ex_valid      <= 1'b0;
      ex_pc         <= 32'd0;
      ex_inst       <= NOP_INST;
      halted        <= 1'b0;
      trap_misalign <= 1'b0;
    end else if (advance) begin
      if (ex_valid && mis) begin
        trap_misalign <= 1'b1;
        halted        <= 1'b1;
      end else if (ex_valid && redirect) begin
        pc_f     <= target;
        ex_valid <= 1'b0;
      end else if (ex_valid && sys_halt) begin
        halted   <= 1'b1;
        ex_valid <= 1'b0;
      end else begin
        ex_inst  <= fetch_inst;
        ex_pc    <= pc_f;
        ex_valid <= 1'b1;
        pc_f     <= pc_f + 32'd4;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{pc_f[31:IW+2], pc_f[1:0], mem_addr[31:DW+2]};

endmodule

// File: tb/tb_pipe_processor.sv
// Directed program bench: main core runs a branch/jump/load-store/ECALL program;
// a second core with HALT_ON_SYS=0 runs into a misaligned JAL target.
module tb_pipe_processor;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // 0x00 ADDI x1,x0,5 | 0x04 ADDI x2,x1,3 | 0x08 ADD x3,x1,x2 | 0x0C SW x2,0(x0)
  // 0x10 BEQ x1,x1,+16 | 0x14 ADDI x6,x0,1 | 0x20 LW x4,0(x0) | 0x24 ADDI x7,x0,0
  // 0x30 JAL x5,+8 | 0x34 ADDI x6,x0,1 | 0x38 BNE x7,x0,+8 | 0x3C JALR x7,5(x5) | 0x40 ECALL
  localparam logic [1023:0] PROG1 = {
    {15{NOP}},
    32'h0000_0073, 32'h0052_83E7, 32'h0003_9463, 32'h0010_0313,
    32'h0080_02EF, NOP,           NOP,           32'h0000_0393,
    32'h0000_2203, NOP,           NOP,           32'h0010_0313,
    32'h0010_8863, 32'h0020_2023, 32'h0020_81B3, 32'h0030_8113,
    32'h0050_0093
  };

  // 0x00 ADDI x1,x0,7 | 0x04 ECALL | 0x08 JAL x1,+6 (target 0x0E)
  localparam logic [1023:0] PROG2 = {
    {29{NOP}}, 32'h0060_00EF, 32'h0000_0073, 32'h0070_0093
  };

  logic        clk, rst, stall;
  logic        retire_valid, halted, trap_misalign;
  logic [31:0] retire_pc, retire_inst;
  logic        rv2, halted2, trap2;
  logic [31:0] pc2, inst2;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_processor #(
    .RESET_PC(32'h0), .HALT_ON_SYS(1'b1), .IMEM_WORDS(32), .DMEM_WORDS(16), .IMEM_INIT(PROG1)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_inst(retire_inst),
    .halted(halted), .trap_misalign(trap_misalign)
  );

  pipe_processor #(
    .RESET_PC(32'h0), .HALT_ON_SYS(1'b0), .IMEM_WORDS(32), .DMEM_WORDS(16), .IMEM_INIT(PROG2)
  ) dut2 (
    .clk(clk), .rst(rst), .stall(1'b0),
    .retire_valid(rv2), .retire_pc(pc2), .retire_inst(inst2),
    .halted(halted2), .trap_misalign(trap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_ret(input string tag, input logic rv, input logic [31:0] pc);
    chk({tag, "_rv"}, 32'(retire_valid), 32'(rv));
    if (rv) chk({tag, "_pc"}, retire_pc, pc);
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    step;
    step;
    chk("rst_rv", 32'(retire_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_trap", 32'(trap_misalign), 32'd0);
    chk("rst_pc", retire_pc, 32'h0);
    chk("rst_inst", retire_inst, NOP);
    chk("rst_rv2", 32'(rv2), 32'd0);
    rst = 1'b0;

    step;
    chk_ret("c1", 1'b1, 32'h00);
    chk("c1_inst", retire_inst, 32'h0050_0093);
    chk("c1_rv2", 32'(rv2), 32'd1);
    step;
    chk_ret("c2", 1'b1, 32'h04);
    chk("c2_ecall_rv2", 32'(rv2), 32'd1);
    chk("c2_ecall_pc2", pc2, 32'h04);
    chk("c2_ecall_inst2", inst2, 32'h0000_0073);
    step;
    chk_ret("c3", 1'b1, 32'h08);
    chk("c3_nohalt2", 32'(halted2), 32'd0);
    chk("c3_misjal_rv2", 32'(rv2), 32'd0);
    step;
    chk_ret("c4_sw", 1'b1, 32'h0C);
    chk("x3", dut.rf[3], 32'd13);
    chk("trap2", 32'(trap2), 32'd1);
    chk("halted2", 32'(halted2), 32'd1);
    chk("halt_rv2", 32'(rv2), 32'd0);
    chk("misjal_no_wb", dut2.rf[1], 32'd7);
    step;
    chk_ret("beq", 1'b1, 32'h10);
    stall = 1'b1;
    step;
    chk_ret("beq_stalled", 1'b0, 32'h0);
    chk("beq_hold_pc", retire_pc, 32'h10);
    stall = 1'b0;
    step;
    chk_ret("beq_bubble", 1'b0, 32'h0);
    step;
    chk_ret("lw", 1'b1, 32'h20);
    stall = 1'b1;
    step;
    chk_ret("stall1", 1'b0, 32'h0);
    step;
    chk_ret("stall2", 1'b0, 32'h0);
    step;
    chk_ret("stall3", 1'b0, 32'h0);
    stall = 1'b0;
    step;
    chk_ret("addi_x7", 1'b1, 32'h24);
    chk("x4_lw", dut.rf[4], 32'd8);
    step;
    chk_ret("nop28", 1'b1, 32'h28);
    step;
    chk_ret("nop2c", 1'b1, 32'h2C);
    step;
    chk_ret("jal", 1'b1, 32'h30);
    step;
    chk_ret("jal_bubble", 1'b0, 32'h0);
    chk("x5_link", dut.rf[5], 32'h34);
    step;
    chk_ret("bne_nt", 1'b1, 32'h38);
    step;
    chk_ret("jalr", 1'b1, 32'h3C);
    step;
    chk_ret("jalr_bubble", 1'b0, 32'h0);
    chk("x7_link", dut.rf[7], 32'h40);
    step;
    chk_ret("bne_t", 1'b1, 32'h38);
    step;
    chk_ret("bne_bubble", 1'b0, 32'h0);
    step;
    chk_ret("ecall", 1'b1, 32'h40);
    chk("ecall_inst", retire_inst, 32'h0000_0073);
    chk("ecall_not_yet_halted", 32'(halted), 32'd0);
    step;
    chk_ret("halt1", 1'b0, 32'h0);
    chk("halted", 32'(halted), 32'd1);
    chk("halt_pcf", dut.pc_f, 32'h44);
    chk("no_trap", 32'(trap_misalign), 32'd0);
    step;
    chk_ret("halt2", 1'b0, 32'h0);

    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rerst_halted", 32'(halted), 32'd0);
    chk("rerst_rv", 32'(retire_valid), 32'd0);
    chk("rf_kept", dut.rf[3], 32'd13);
    step;
    chk_ret("restart", 1'b1, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
